// File: rtl/alloc_pkg.sv
// Shared definitions for the round-robin switch allocator.
//   state_t   : allocator FSM states (ARB, SEND, WAIT)
//   MODE_RR   : work-conserving round-robin arbitration
//   MODE_TDM  : fixed time-slot arbitration
//   ptr_w()   : width of the priority pointer for a given port count
package alloc_pkg;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int MODE_RR  = 0;
  localparam int MODE_TDM = 1;

  // A 2-port pointer still needs one bit; $clog2(2) already gives that,
  // the guard only protects degenerate counts.
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter for the switch allocator.
//   i_request : per-port request vector
//   i_ptr     : current priority pointer (0 .. NUM_PORTS-1)
//   o_onehot  : one-hot winner, zero when nobody wins
//   o_idx     : winner index (valid only with o_valid)
//   o_valid   : a winner exists
// MODE_RR picks the requester closest to i_ptr going upward with wrap;
// MODE_TDM only lets the port equal to i_ptr win.
module rr_arbiter
  import alloc_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int MODE      = MODE_RR,
  localparam int PW       = ptr_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_request,
  input  logic [PW-1:0]        i_ptr,
  output logic [NUM_PORTS-1:0] o_onehot,
  output logic [PW-1:0]        o_idx,
  output logic                 o_valid
);

  int w_best;
  int w_dist;

  // Distance from the pointer is computed per port with an explicit wrap,
  // so the search works for non-power-of-two port counts.
  always_comb begin
    w_best = NUM_PORTS;
    w_dist = 0;
    o_idx  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_dist = i - int'(i_ptr);
      if (w_dist < 0) w_dist = w_dist + NUM_PORTS;
      if (i_request[i] && (MODE != MODE_TDM || w_dist == 0) && w_dist < w_best) begin
        w_best = w_dist;
        o_idx  = PW'(i);
      end
    end
    o_valid = (w_best < NUM_PORTS);
  end

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      o_onehot[i] = o_valid && (o_idx == PW'(i));
    end
  end

endmodule

// File: rtl/rr_switch_allocator.sv
// Switch allocator: arbitrates among NUM_PORTS requesters, latches the
// winner's data word and multicasts it to every destination flagged empty.
//   clk, rst  : clock, asynchronous active-high reset
//   request   : per-port request, held until grant is seen
//   empty     : per-destination "can accept" flags
//   data_i    : packed input words, port i at [i*DATA_W +: DATA_W]
//   grant     : registered one-hot winner pulse
//   sel_data  : registered winning word, held until the next grant
//   fill      : registered multicast write strobes (one-cycle pulse)
//   busy      : a transfer is in flight (SEND or WAIT)
module rr_switch_allocator
  import alloc_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int DATA_W    = 8,
  parameter int MODE      = MODE_RR,
  parameter int PRIO_INIT = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        request,
  input  logic [NUM_PORTS-1:0]        empty,
  input  logic [NUM_PORTS*DATA_W-1:0] data_i,
  output logic [NUM_PORTS-1:0]        grant,
  output logic [DATA_W-1:0]           sel_data,
  output logic [NUM_PORTS-1:0]        fill,
  output logic                        busy
);

  localparam int PW = ptr_w(NUM_PORTS);

  state_t               r_state;
  logic [PW-1:0]        r_ptr;
  logic [NUM_PORTS-1:0] r_grant;
  logic [NUM_PORTS-1:0] r_fill;
  logic [DATA_W-1:0]    r_sel;

  logic [NUM_PORTS-1:0] w_onehot;
  logic [PW-1:0]        w_idx;
  logic                 w_valid;
  logic [DATA_W-1:0]    w_word;

  // Wrap explicitly at NUM_PORTS-1 rather than relying on pointer overflow.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(NUM_PORTS - 1)) return '0;
    return p + PW'(1);
  endfunction

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .MODE      (MODE)
  ) u_arb (
    .i_request (request),
    .i_ptr     (r_ptr),
    .o_onehot  (w_onehot),
    .o_idx     (w_idx),
    .o_valid   (w_valid)
  );

  always_comb begin
    w_word = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_idx == PW'(i)) w_word = data_i[i*DATA_W +: DATA_W];
    end
  end

  // grant and fill default to zero each cycle so both are single-cycle
  // pulses; they live in different states and can never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB;
      r_ptr   <= PW'(PRIO_INIT);
      r_grant <= '0;
      r_fill  <= '0;
      r_sel   <= '0;
    end else begin
      r_grant <= '0;
      r_fill  <= '0;
      case (r_state)
        ARB: begin
          if (w_valid) begin
            r_grant <= w_onehot;
            r_sel   <= w_word;
            r_ptr   <= ptr_inc(w_idx);
            r_state <= SEND;
          end else if (MODE == MODE_TDM) begin
            r_ptr <= ptr_inc(r_ptr);
          end
        end
        // SEND and WAIT share the release rule: fill on the first cycle a
        // destination is free, otherwise keep waiting with sel_data held.
        SEND, WAIT: begin
          if (|empty) begin
            r_fill  <= empty;
            r_state <= ARB;
          end else begin
            r_state <= WAIT;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign grant    = r_grant;
  assign fill     = r_fill;
  assign sel_data = r_sel;
  assign busy     = (r_state != ARB);

endmodule

// File: tb/tb_rr_switch_allocator.sv
// Scoreboard bench for rr_switch_allocator: three configurations
// (5-port round-robin, 5-port TDM, 3-port 16-bit round-robin) run side by
// side under random traffic, each against a transaction-level model.
module tb_rr_switch_allocator;

  logic clk;
  logic rst;
  bit   run;
  bit   drain;
  bit   done;
  int   n_chk;
  int   n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input bit ok,
                       input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen_cfg
    localparam int N  = (g == 2) ? 3 : 5;
    localparam int DW = (g == 2) ? 16 : 8;
    localparam int MD = (g == 1) ? 1 : 0;
    localparam int PI = (g == 2) ? 2 : 0;

    logic [N-1:0]    request;
    logic [N-1:0]    empty;
    logic [N*DW-1:0] data_i;
    logic [N-1:0]    grant;
    logic [DW-1:0]   sel_data;
    logic [N-1:0]    fill;
    logic            busy;

    rr_switch_allocator #(
      .NUM_PORTS (N),
      .DATA_W    (DW),
      .MODE      (MD),
      .PRIO_INIT (PI)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .request  (request),
      .empty    (empty),
      .data_i   (data_i),
      .grant    (grant),
      .sel_data (sel_data),
      .fill     (fill),
      .busy     (busy)
    );

    // Expected transactions
    int            gq[$];
    logic [DW-1:0] dq[$];
    logic [N-1:0]  fq[$];
    logic [DW-1:0] exp_sel = '0;
    int            m_ptr = PI;
    bit            m_inflight = 1'b0;
    int            m_w;

    // Reference model: a transfer is either in flight or not. When idle,
    // the winner is the requester nearest the pointer (RR) or the pointer
    // itself (TDM); an in-flight transfer completes on any nonzero empty.
    initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_ptr = PI;
        m_inflight = 1'b0;
        gq.delete();
        dq.delete();
        fq.delete();
        exp_sel = '0;
      end else if (!m_inflight) begin
        m_w = -1;
        if (MD == 0) begin
          for (int k = 0; k < N; k++)
            if (m_w < 0 && request[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
        end else if (request[m_ptr]) begin
          m_w = m_ptr;
        end
        if (m_w >= 0) begin
          gq.push_back(m_w);
          dq.push_back(data_i[m_w*DW +: DW]);
          m_ptr = (m_w + 1) % N;
          m_inflight = 1'b1;
        end else if (MD == 1) begin
          m_ptr = (m_ptr + 1) % N;
        end
      end else if (empty != '0) begin
        fq.push_back(empty);
        m_inflight = 1'b0;
      end
    end

    // Requesters: raise at random, drop on the cycle grant is seen.
    initial begin
      request = '0;
      empty   = '0;
      data_i  = '0;
      forever begin
        @(negedge clk);
        if (drain) begin
          request = '0;
          empty   = '1;
        end else if (run) begin
          for (int i = 0; i < N; i++) begin
            if (grant[i]) request[i] = 1'b0;
            else if (!request[i] && $urandom_range(3) == 0) request[i] = 1'b1;
          end
          empty = ($urandom_range(3) == 0) ? '0 : N'($urandom);
          for (int i = 0; i < N; i++) data_i[i*DW +: DW] = DW'($urandom);
        end
      end
    end

    // Monitor: pop and compare whenever the DUT presents grant or fill.
    initial forever begin
      int            w;
      logic [DW-1:0] d;
      logic [N-1:0]  f;
      @(negedge clk);
      if (!rst && run) begin
        if (grant != '0) begin
          if (gq.size() == 0) begin
            check($sformatf("c%0d_unexpected_grant", g), 1'b0, 64'(grant), 64'(0));
          end else begin
            w = gq.pop_front();
            d = dq.pop_front();
            check($sformatf("c%0d_grant", g), grant == N'(1 << w), 64'(grant), 64'(1 << w));
            exp_sel = d;
          end
        end
        if (fill != '0) begin
          if (fq.size() == 0) begin
            check($sformatf("c%0d_unexpected_fill", g), 1'b0, 64'(fill), 64'(0));
          end else begin
            f = fq.pop_front();
            check($sformatf("c%0d_fill", g), fill == f, 64'(fill), 64'(f));
          end
        end
        check($sformatf("c%0d_grant_fill_excl", g), !(grant != '0 && fill != '0),
              64'({grant, fill}), 64'(0));
        check($sformatf("c%0d_sel_data", g), sel_data == exp_sel, 64'(sel_data), 64'(exp_sel));
        check($sformatf("c%0d_busy", g), busy == m_inflight, 64'(busy), 64'(m_inflight));
      end
    end

    // Asynchronous reset must clear outputs without waiting for a clock.
    initial forever begin
      @(posedge rst);
      #1;
      check($sformatf("c%0d_rst_grant", g), grant == '0, 64'(grant), 64'(0));
      check($sformatf("c%0d_rst_fill", g), fill == '0, 64'(fill), 64'(0));
      check($sformatf("c%0d_rst_sel", g), sel_data == '0, 64'(sel_data), 64'(0));
      check($sformatf("c%0d_rst_busy", g), busy == 1'b0, 64'(busy), 64'(0));
    end

    initial begin
      wait (done);
      check($sformatf("c%0d_grant_q_empty", g), gq.size() == 0, 64'(gq.size()), 64'(0));
      check($sformatf("c%0d_fill_q_empty", g), fq.size() == 0, 64'(fq.size()), 64'(0));
    end
  end

  initial begin
    int i;
    rst   = 1'b0;
    run   = 1'b0;
    drain = 1'b0;
    done  = 1'b0;
    n_chk = 0;
    n_fail = 0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    repeat (400) @(negedge clk);

    // Reset in the middle of a transfer: wait until config 0 shows a grant.
    for (i = 0; i < 200; i++) begin
      if (gen_cfg[0].grant != '0) break;
      @(negedge clk);
    end
    check("wait_grant_before_reset", gen_cfg[0].grant != '0, 64'(gen_cfg[0].grant), 64'(1));
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    repeat (600) @(negedge clk);
    drain = 1'b1;
    repeat (20) @(negedge clk);
    run  = 1'b0;
    done = 1'b1;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
